secded_write_pipe: RTL and testbench
====================================

Name: secded_write_pipe

Overview:
- Write-path stage directly upstream of the data/address bank demultiplexers.
- Accepts raw write requests via valid/ready and Hamming-encodes the data with an extra overall-parity bit (SECDED).
- Splits the address into bank select (top two bits) and row, then presents a registered, encoded request downstream.
- Two-stage pipeline with full backpressure; optional single-bit error injection for decoder verification.

Parameters:
- DATA_WIDTH, 8, raw data width.
- ADDR_WIDTH, 4, full write address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select one of 4 banks.
- PARITY_BITS, $clog2(DATA_WIDTH)+1, Hamming check bits.
- ENCODED_WORD, DATA_WIDTH+PARITY_BITS, Hamming codeword width; output word is ENCODED_WORD+1 bits.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  write request valid.
- o_ready  output  1  stage can accept a request this cycle.
- i_addr  input  ADDR_WIDTH  write address.
- i_data  input  DATA_WIDTH  raw write data.
- i_inj_en  input  1  flip one codeword bit of this request.
- i_inj_pos  input  $clog2(ENCODED_WORD+2)  bit position to flip, 1..ENCODED_WORD+1.
- o_valid  output  1  encoded request valid.
- i_ready  input  1  downstream accepts.
- o_data  output  [ENCODED_WORD+1:1]  SECDED codeword.
- o_sel  output  2  bank select = i_addr[ADDR_WIDTH-1:ADDR_WIDTH-2].
- o_row  output  ADDR_WIDTH-2  row address within bank.

Behaviour:
- Reset (async, i_rst=1): s1_valid=0, s2_valid=0, o_valid=0, o_data=0, o_sel=0, o_row=0; o_ready=1 once i_rst deasserts. Reset mid-flight drops in-flight requests silently.
- Stage 1 (S1) registers addr, data, inj_en, inj_pos when i_valid && o_ready.
- Stage 2 (S2) encodes the S1 contents and registers codeword, sel, row; S2 outputs drive o_* directly.
- Advance rules: s2_load = s1_valid && (!s2_valid || i_ready). o_ready = !s1_valid || s2_load (combinational pass-through of i_ready permitted).
- Latency: 2 cycles from accept to o_valid. Throughput: 1 per cycle while i_ready=1.
- Stall: while o_valid && !i_ready, o_data/o_sel/o_row hold stable. S1 holds; o_ready=0 if S1 is full.
- Simultaneous accept and drain in the same cycle must not lose or duplicate requests.
- Codeword layout:
  - Positions 1..ENCODED_WORD use standard Hamming; check bits sit at power-of-two positions (1,2,4,8).
  - Data bits go LSB-first into the remaining positions (d0->3, d1->5, d2->6, d3->7, d4->9 ... d7->12).
  - Check bit p_k is the XOR of all positions whose index has bit k set.
  - Position ENCODED_WORD+1 = XOR of positions 1..ENCODED_WORD (even overall parity).
- Injection: if inj_en, flip o_data[inj_pos] after overall parity is computed. inj_pos=0 or > ENCODED_WORD+1 means no flip.
- X-safety: i_addr/i_data are ignored when i_valid=0.

Decomposition:
- Shared package holds:
  - PARITY_BITS/ENCODED_WORD derivation functions.
  - Is-power-of-two position function.
  - Data-to-position map function.
  - NUM_BANKS=4 and SEL_WIDTH=2 constants.
- Same package is reused by the read-side decoder.
- One combinational sub-module, hamming_secded_gen (data in, [ENCODED_WORD+1:1] codeword out), instantiated in S2.

Test Plan:
- Reset then i_data=8'hA5, i_addr=4'hB, i_valid=1 pulse, i_ready=1 -> 2 cycles later o_valid=1, o_data=13'h0A27, o_sel=2'b10, o_row=2'b11.
- i_data=8'h01 and 8'h00 back-to-back, i_ready=1 -> o_data=13'h1007 then 13'h0000 on consecutive cycles; o_ready stays 1.
- Stream 4 requests, hold i_ready=0 for 5 cycles -> o_data holds the first word, o_ready=0 after S1 fills; on release all 4 emerge in order, none lost or duplicated.
- i_data=8'hA5 with i_inj_en=1, i_inj_pos=3 -> o_data=13'h0A23; with i_inj_pos=13 -> 13'h1A27; with i_inj_pos=0 -> 13'h0A27.
- Assert i_rst asynchronously with both stages full -> o_valid=0 and o_data=0 immediately; after deassert, the next request emerges with 2-cycle latency.
- Random data across all 256 values -> reference decoder reports zero syndrome and even overall parity for every word.

Source files
------------

// File: rtl/secded_write_pipe_pkg.sv
// Shared SECDED helpers for the bank write path and read-side decoder.
// Position math for Hamming codewords with an overall parity bit.
package secded_write_pipe_pkg;

  localparam int NUM_BANKS = 4;
  localparam int SEL_WIDTH = 2;

  function automatic int calc_parity_bits(input int dw);
    return $clog2(dw) + 1;
  endfunction

  function automatic int calc_encoded_word(input int dw);
    return dw + calc_parity_bits(dw);
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit idx: idx-th non-power-of-two slot
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 256; p++) begin
      if (!is_pow2(p) && pos == 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_write_pipe_if.sv
// Request/response bundle between the write source and the bank demux.
// slave faces the pipe; master faces the source and sink.
interface secded_write_pipe_if
  import secded_write_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int EW = calc_encoded_word(DATA_WIDTH);
  localparam int IW = $clog2(EW + 2);

  logic                    i_valid;
  logic                    o_ready;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_inj_en;
  logic [IW-1:0]           i_inj_pos;
  logic                    o_valid;
  logic                    i_ready;
  logic [EW+1:1]           o_data;
  logic [SEL_WIDTH-1:0]    o_sel;
  logic [ADDR_WIDTH-3:0]   o_row;

  modport slave (
    input  i_valid, i_addr, i_data,
    input  i_inj_en, i_inj_pos, i_ready,
    output o_ready, o_valid, o_data,
    output o_sel, o_row
  );

  modport master (
    output i_valid, i_addr, i_data,
    output i_inj_en, i_inj_pos, i_ready,
    input  o_ready, o_valid, o_data,
    input  o_sel, o_row
  );

endinterface

// File: rtl/secded_write_pipe_gen.sv
// Combinational Hamming encoder plus overall even-parity bit.
// Check bits sit at power-of-two positions of the codeword.
module hamming_secded_gen
  import secded_write_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int PB = calc_parity_bits(DATA_WIDTH),
  localparam int EW = calc_encoded_word(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [EW+1:1]         code_o
);

  logic [EW:1] w;
  logic        p;

  always_comb begin
    w = '0;
    p = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w[data_pos(i)] = data_i[i];
    end
    // Check slots are still zero here, so XOR over all covered slots is safe
    for (int k = 0; k < PB; k++) begin
      p = 1'b0;
      for (int j = 1; j <= EW; j++) begin
        if (j[k]) p = p ^ w[j];
      end
      w[1 << k] = p;
    end
    code_o = {^w, w};
  end

endmodule

// File: rtl/secded_write_pipe.sv
// Two-stage SECDED write pipe: S1 captures the request, S2 holds the
// encoded word, bank select and row for the downstream demux.
module secded_write_pipe
  import secded_write_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int PARITY_BITS  = calc_parity_bits(DATA_WIDTH),
  parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  secded_write_pipe_if.slave bus
);

  localparam int IW = $clog2(ENCODED_WORD + 2);
  localparam int RW = ADDR_WIDTH - SEL_WIDTH;

  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_inj_en_q;
  logic [IW-1:0]         s1_inj_pos_q;

  logic                    s2_valid_q, s2_valid_d;
  logic [ENCODED_WORD+1:1] s2_code_q, s2_code_d;
  logic [SEL_WIDTH-1:0]    s2_sel_q;
  logic [RW-1:0]           s2_row_q;

  logic                    s1_load, s2_load;
  logic [ENCODED_WORD+1:1] code;

  assign s2_load     = s1_valid_q && (!s2_valid_q || bus.i_ready);
  assign bus.o_ready = !s1_valid_q || s2_load;
  assign s1_load     = bus.i_valid && bus.o_ready;

  hamming_secded_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gen (
    .data_i (s1_data_q),
    .code_o (code)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_code_d  = code;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    if (s2_load)          s2_valid_d = 1'b1;
    else if (bus.i_ready) s2_valid_d = 1'b0;
    // Flip after overall parity; pos 0 or out of range never matches
    for (int j = 1; j <= ENCODED_WORD + 1; j++) begin
      if (s1_inj_en_q && s1_inj_pos_q == IW'(j)) begin
        s2_code_d[j] = ~code[j];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      s1_inj_en_q  <= 1'b0;
      s1_inj_pos_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_addr_q    <= bus.i_addr;
        s1_data_q    <= bus.i_data;
        s1_inj_en_q  <= bus.i_inj_en;
        s1_inj_pos_q <= bus.i_inj_pos;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      s2_sel_q   <= '0;
      s2_row_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_code_q <= s2_code_d;
        s2_sel_q  <= s1_addr_q[ADDR_WIDTH-1 -: SEL_WIDTH];
        s2_row_q  <= s1_addr_q[RW-1:0];
      end
    end
  end

  assign bus.o_valid = s2_valid_q;
  assign bus.o_data  = s2_code_q;
  assign bus.o_sel   = s2_sel_q;
  assign bus.o_row   = s2_row_q;

endmodule

// File: tb/tb_secded_write_pipe.sv
// Directed plus permuted-data bench for secded_write_pipe.
// Scoreboard queue is filled on accept and drained on output handshake.
module tb_secded_write_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   rnd_done = 1'b0;

  typedef struct {
    logic [12:0] cw;
    logic [1:0]  sel;
    logic [1:0]  row;
    bit          inj;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  secded_write_pipe_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  secded_write_pipe #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [13:1] w;
    int pos_tab[8];
    logic par;
    pos_tab = '{3, 5, 6, 7, 9, 10, 11, 12};
    w = '0;
    for (int i = 0; i < 8; i++) w[pos_tab[i]] = d[i];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int j = 1; j <= 12; j++)
        if ((j & (1 << k)) != 0) par ^= w[j];
      w[1 << k] = par;
    end
    w[13] = ^w[12:1];
    return w;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] a,
                      input bit inj, input logic [3:0] pos,
                      input logic [12:0] cw, input bit chk_rdy);
    int t;
    exp_t x;
    @(negedge clk);
    bus.i_valid   = 1'b1;
    bus.i_data    = d;
    bus.i_addr    = a;
    bus.i_inj_en  = inj;
    bus.i_inj_pos = pos;
    #1;
    if (chk_rdy) check("o_ready_stream", 32'(bus.o_ready), 32'd1);
    t = 0;
    while (!bus.o_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=stalled expected=accept");
    end else begin
      x.cw  = cw;
      x.sel = a[3:2];
      x.row = a[1:0];
      x.inj = inj && pos >= 1 && pos <= 13;
      sb.push_back(x);
      @(posedge clk);
    end
    #1;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'($urandom);
    bus.i_addr  = 4'($urandom);
  endtask

  task automatic send_m(input logic [7:0] d, input logic [3:0] a);
    send(d, a, 1'b0, 4'd0, enc(d), 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed=%h expected=none",
               bus.o_data);
      end else begin
        int syn;
        e = sb.pop_front();
        check("o_data", 32'(bus.o_data), 32'(e.cw));
        check("o_sel", 32'(bus.o_sel), 32'(e.sel));
        check("o_row", 32'(bus.o_row), 32'(e.row));
        if (!e.inj) begin
          syn = 0;
          for (int j = 1; j <= 12; j++)
            if (bus.o_data[j]) syn ^= j;
          check("syndrome", 32'(syn), 32'd0);
          check("overall_parity", 32'(^bus.o_data), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    bus.i_addr    = '0;
    bus.i_inj_en  = 1'b0;
    bus.i_inj_pos = '0;
    bus.i_ready   = 1'b1;
    #1;
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_data", 32'(bus.o_data), 32'd0);
    check("rst_o_sel", 32'(bus.o_sel), 32'd0);
    check("rst_o_row", 32'(bus.o_row), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_o_ready", 32'(bus.o_ready), 32'd1);

    send(8'hA5, 4'hB, 1'b0, 4'd0, 13'h0A27, 1'b1);
    send(8'h01, 4'h2, 1'b0, 4'd0, 13'h1007, 1'b1);
    send(8'h00, 4'h7, 1'b0, 4'd0, 13'h0000, 1'b1);
    repeat (4) @(negedge clk);

    send(8'hA5, 4'hB, 1'b1, 4'd3, 13'h0A23, 1'b0);
    send(8'hA5, 4'h4, 1'b1, 4'd13, 13'h1A27, 1'b0);
    send(8'hA5, 4'h9, 1'b1, 4'd0, 13'h0A27, 1'b0);
    send(8'hA5, 4'h1, 1'b1, 4'd15, 13'h0A27, 1'b0);
    repeat (4) @(negedge clk);

    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    fork
      begin
        send(8'hA5, 4'hB, 1'b0, 4'd0, 13'h0A27, 1'b0);
        send_m(8'h3C, 4'h6);
        send_m(8'h5A, 4'hD);
        send_m(8'hFF, 4'h0);
      end
      begin
        repeat (4) @(negedge clk);
        #2;
        check("stall_o_valid", 32'(bus.o_valid), 32'd1);
        check("stall_o_ready", 32'(bus.o_ready), 32'd0);
        repeat (2) begin
          check("stall_hold", 32'(bus.o_data), 32'h0A27);
          @(negedge clk);
          #2;
        end
        check("stall_hold_end", 32'(bus.o_data), 32'h0A27);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);

    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    send_m(8'h12, 4'h3);
    send_m(8'h34, 4'hC);
    @(negedge clk);
    #2;
    check("full_o_ready", 32'(bus.o_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_o_valid", 32'(bus.o_valid), 32'd0);
    check("arst_o_data", 32'(bus.o_data), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hA5;
    bus.i_addr  = 4'hB;
    bus.i_inj_en = 1'b0;
    begin
      exp_t x;
      x.cw = 13'h0A27; x.sel = 2'b10; x.row = 2'b11; x.inj = 1'b0;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    check("lat_edge1", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2", 32'(bus.o_valid), 32'd1);
    check("lat_data", 32'(bus.o_data), 32'h0A27);
    repeat (3) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 256; i++)
          send_m(8'((i * 37 + 11) & 255), 4'($urandom));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.i_ready = ($urandom_range(0, 3) != 0);
        end
        bus.i_ready = 1'b1;
      end
    join
    bus.i_ready = 1'b1;

    begin
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
